// File: rtl/mem_access_ctrl_if.sv
// Request/response and memory-bus bundle for mem_access_ctrl.
// The slave side is the controller; the master side is the sequencer plus the memory model.
interface mem_access_ctrl_if;
  logic [7:0]  m1_content;
  logic [7:0]  m2_content;
  logic        rd_req;
  logic        wr_req;
  logic [7:0]  wr_data;
  logic        busy;
  logic        done;
  logic        err;
  logic [7:0]  rd_data;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ready;
  logic        led_rd;
  logic        led_wr;

  modport master (
    output m1_content, m2_content, rd_req, wr_req, wr_data, mem_rdata, mem_ready,
    input  busy, done, err, rd_data, mem_addr, mem_rd, mem_wr, mem_wdata, led_rd, led_wr
  );

  modport slave (
    input  m1_content, m2_content, rd_req, wr_req, wr_data, mem_rdata, mem_ready,
    output busy, done, err, rd_data, mem_addr, mem_rd, mem_wr, mem_wdata, led_rd, led_wr
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Memory access sequencer: latches {M1,M2} on a request and runs a setup/strobe/hold cycle
// with wait-state and timeout handling. It returns read data and a one-cycle done pulse.
module mem_access_ctrl #(
  parameter int unsigned SETUP_CYCLES = 1,
  parameter int unsigned WAIT_CYCLES  = 2,
  parameter int unsigned TIMEOUT      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_access_ctrl_if.slave  bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETUP  = 3'd1;
  localparam logic [2:0] S_STROBE = 3'd2;
  localparam logic [2:0] S_HOLD   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [7:0] SETUP_W = 8'(SETUP_CYCLES);
  localparam logic [7:0] WAIT_W  = 8'(WAIT_CYCLES);
  localparam logic [7:0] TO_W    = 8'(TIMEOUT);

  logic [2:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        is_wr_q, is_wr_d;
  logic        abort_q, abort_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    is_wr_d = is_wr_q;
    abort_d = abort_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.rd_req && bus.wr_req) begin
          err_d = 1'b1;
        end else if (bus.rd_req || bus.wr_req) begin
          addr_d  = {bus.m1_content, bus.m2_content};
          is_wr_d = bus.wr_req;
          if (bus.wr_req) wdata_d = bus.wr_data;
          abort_d = 1'b0;
          cnt_d   = 8'd1;
          state_d = S_SETUP;
        end
      end

      // Strobes are set/cleared on the transition edges so they stay pure register outputs.
      S_SETUP: begin
        if (cnt_q >= SETUP_W) begin
          state_d = S_STROBE;
          cnt_d   = 8'd1;
          rd_d    = !is_wr_q;
          wr_d    = is_wr_q;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      S_STROBE: begin
        if (cnt_q >= WAIT_W && bus.mem_ready) begin
          if (!is_wr_q) rdata_d = bus.mem_rdata;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          cnt_d   = '0;
          state_d = S_HOLD;
        end else if (cnt_q == TO_W) begin
          abort_d = 1'b1;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          cnt_d   = '0;
          state_d = S_HOLD;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      S_HOLD: begin
        done_d  = 1'b1;
        err_d   = abort_q;
        state_d = S_DONE;
      end

      S_DONE:  state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      is_wr_q <= 1'b0;
      abort_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      is_wr_q <= is_wr_d;
      abort_q <= abort_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.rd_data   = rdata_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_rd    = rd_q;
  assign bus.mem_wr    = wr_q;
  assign bus.led_rd    = rd_q;
  assign bus.led_wr    = wr_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with default parameters; expected values are hand-derived.
module tb_mem_access_ctrl;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_err;

  mem_access_ctrl_if bus ();

  mem_access_ctrl #(
    .SETUP_CYCLES(1),
    .WAIT_CYCLES (2),
    .TIMEOUT     (16)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  int wr_width;
  int rd_width;
  int done_cyc;
  int done_cnt;
  logic err_at_done;
  logic overlap;

  initial begin
    n_checks = 0;
    n_err    = 0;
    rst_n    = 1'b0;
    bus.m1_content = '0;
    bus.m2_content = '0;
    bus.rd_req     = 1'b0;
    bus.wr_req     = 1'b0;
    bus.wr_data    = '0;
    bus.mem_rdata  = '0;
    bus.mem_ready  = 1'b0;

    tick();
    tick();
    check("rst_busy",  {15'd0, bus.busy},   16'd0);
    check("rst_done",  {15'd0, bus.done},   16'd0);
    check("rst_err",   {15'd0, bus.err},    16'd0);
    check("rst_strb",  {14'd0, bus.mem_rd, bus.mem_wr}, 16'd0);
    check("rst_led",   {14'd0, bus.led_rd, bus.led_wr}, 16'd0);
    check("rst_addr",  bus.mem_addr,         16'h0000);
    check("rst_rdata", {8'd0, bus.rd_data},  16'h0000);
    check("rst_wdata", {8'd0, bus.mem_wdata},16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Read with defaults: SETUP c1, STROBE c2-3, HOLD c4, DONE c5.
    bus.m1_content = 8'h12;
    bus.m2_content = 8'h34;
    bus.mem_ready  = 1'b1;
    bus.mem_rdata  = 8'hA5;
    bus.rd_req     = 1'b1;
    tick();
    bus.rd_req = 1'b0;
    check("rd_c1_busy", {15'd0, bus.busy},   16'd1);
    check("rd_c1_addr", bus.mem_addr,        16'h1234);
    check("rd_c1_strb", {15'd0, bus.mem_rd}, 16'd0);
    tick();
    check("rd_c2_strb", {14'd0, bus.mem_rd, bus.led_rd}, 16'b11);
    tick();
    check("rd_c3_strb", {15'd0, bus.mem_rd}, 16'd1);
    tick();
    check("rd_c4_strb", {15'd0, bus.mem_rd}, 16'd0);
    check("rd_c4_done", {15'd0, bus.done},   16'd0);
    check("rd_c4_data", {8'd0, bus.rd_data}, 16'h00A5);
    tick();
    check("rd_c5_done", {15'd0, bus.done},   16'd1);
    check("rd_c5_err",  {15'd0, bus.err},    16'd0);
    check("rd_c5_data", {8'd0, bus.rd_data}, 16'h00A5);
    tick();
    check("rd_c6_done", {15'd0, bus.done},   16'd0);
    check("rd_c6_busy", {15'd0, bus.busy},   16'd0);

    // Write with mem_ready low for the first three STROBE cycles.
    bus.m1_content = 8'hFF;
    bus.m2_content = 8'hFF;
    bus.wr_data    = 8'h5A;
    bus.mem_ready  = 1'b0;
    bus.mem_rdata  = 8'h99;
    bus.wr_req     = 1'b1;
    tick();
    bus.wr_req = 1'b0;
    check("wr_c1_addr",  bus.mem_addr,          16'hFFFF);
    check("wr_c1_wdata", {8'd0, bus.mem_wdata}, 16'h005A);
    wr_width = 0;
    done_cyc = -1;
    overlap  = 1'b0;
    for (int c = 2; c <= 10; c++) begin
      tick();
      if (c == 5) bus.mem_ready = 1'b1;
      if (bus.mem_wr) wr_width++;
      if (bus.mem_wr && bus.mem_rd) overlap = 1'b1;
      if (bus.done && done_cyc < 0) done_cyc = c;
    end
    check("wr_width",   16'(wr_width),         16'd4);
    check("wr_done_at", 16'(done_cyc),         16'd7);
    check("wr_overlap", {15'd0, overlap},      16'd0);
    check("wr_rdata",   {8'd0, bus.rd_data},   16'h00A5);
    check("wr_wdata",   {8'd0, bus.mem_wdata}, 16'h005A);

    // Conflicting request in IDLE.
    bus.rd_req = 1'b1;
    bus.wr_req = 1'b1;
    tick();
    bus.rd_req = 1'b0;
    bus.wr_req = 1'b0;
    check("cf_err",  {15'd0, bus.err},  16'd1);
    check("cf_busy", {15'd0, bus.busy}, 16'd0);
    check("cf_strb", {14'd0, bus.mem_rd, bus.mem_wr}, 16'd0);
    tick();
    check("cf_err2", {15'd0, bus.err},  16'd0);
    check("cf_busy2",{15'd0, bus.busy}, 16'd0);

    // Timeout: strobe c2..c17, HOLD c18, DONE c19 with err.
    bus.m1_content = 8'h00;
    bus.m2_content = 8'h10;
    bus.mem_ready  = 1'b0;
    bus.mem_rdata  = 8'h3C;
    bus.rd_req     = 1'b1;
    tick();
    bus.rd_req  = 1'b0;
    rd_width    = 0;
    done_cyc    = -1;
    err_at_done = 1'b0;
    for (int c = 2; c <= 24; c++) begin
      tick();
      if (bus.mem_rd) rd_width++;
      if (bus.done && done_cyc < 0) begin
        done_cyc    = c;
        err_at_done = bus.err;
      end
    end
    check("to_width",   16'(rd_width),       16'd16);
    check("to_done_at", 16'(done_cyc),       16'd19);
    check("to_err",     {15'd0, err_at_done},16'd1);
    check("to_rdata",   {8'd0, bus.rd_data}, 16'h00A5);

    // Request and address change during STROBE are ignored.
    bus.m1_content = 8'hAB;
    bus.m2_content = 8'hCD;
    bus.mem_ready  = 1'b1;
    bus.mem_rdata  = 8'h77;
    bus.rd_req     = 1'b1;
    tick();
    bus.rd_req = 1'b0;
    tick();
    bus.m1_content = 8'h11;
    bus.m2_content = 8'h22;
    bus.rd_req     = 1'b1;
    tick();
    bus.rd_req = 1'b0;
    check("ig_addr", bus.mem_addr, 16'hABCD);
    done_cnt = 0;
    for (int c = 3; c <= 12; c++) begin
      if (bus.done) done_cnt++;
      tick();
    end
    check("ig_dones", 16'(done_cnt),        16'd1);
    check("ig_rdata", {8'd0, bus.rd_data},  16'h0077);
    check("ig_busy",  {15'd0, bus.busy},    16'd0);

    // Asynchronous reset while strobing, then a fresh read.
    bus.m1_content = 8'h12;
    bus.m2_content = 8'h34;
    bus.mem_rdata  = 8'hE1;
    bus.rd_req     = 1'b1;
    tick();
    bus.rd_req = 1'b0;
    tick();
    check("ar_strb_pre", {15'd0, bus.mem_rd}, 16'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_strb", {14'd0, bus.mem_rd, bus.led_rd}, 16'd0);
    check("ar_busy", {15'd0, bus.busy},    16'd0);
    check("ar_addr", bus.mem_addr,         16'h0000);
    check("ar_data", {8'd0, bus.rd_data},  16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("ar_nodone", {15'd0, bus.done}, 16'd0);
    bus.rd_req = 1'b1;
    tick();
    bus.rd_req = 1'b0;
    check("ar2_addr", bus.mem_addr, 16'h1234);
    done_cyc = -1;
    for (int c = 2; c <= 8; c++) begin
      tick();
      if (bus.done && done_cyc < 0) done_cyc = c;
    end
    check("ar2_done_at", 16'(done_cyc),       16'd5);
    check("ar2_rdata",   {8'd0, bus.rd_data}, 16'h00E1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
